hit_event_gen: RTL and testbench
================================

HIT_EVENT_GEN -- requirements
Module: hit_event_gen

Interface
REQ-001 Parameter PW, default 16: player sprite width in pixels.
REQ-002 Parameter PH, default 16: player sprite height in pixels.
REQ-003 Parameter HW, default 16: hazard width in pixels.
REQ-004 Parameter HH, default 16: hazard height in pixels.
REQ-005 Parameter IFRAMES, default 60: invincibility length in frames; legal range 1..255.
REQ-006 Parameter FLASH_FRAMES, default 4: blink half-period in frames; legal range 1..15.
REQ-007 clk  input  1  single system clock; all state changes on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 frame_tick  input  1  one-cycle pulse per video frame.
REQ-010 player_x, player_y  input  10 each  player top-left pixel coordinate.
REQ-011 haz_x, haz_y  input  10 each  hazard top-left pixel coordinate.
REQ-012 haz_valid  input  1  hazard is present on screen.
REQ-013 wasHit  output  1  one-cycle hit pulse, consumed by the life/RGB indicator.
REQ-014 lives_left  output  2  remaining lives, 3..0.
REQ-015 game_over  output  1  high in DEAD.
REQ-016 player_visible  output  1  sprite draw enable.

Function
REQ-017 Overlap SHALL be combinational, computed in 11-bit unsigned arithmetic (no wrap): haz_valid & (player_x < haz_x+HW) & (haz_x < player_x+PW) & (player_y < haz_y+HH) & (haz_y < player_y+PH).
REQ-018 Edge contact (player_x+PW == haz_x, etc.) SHALL NOT count as overlap.
REQ-019 Overlap SHALL be evaluated only in cycles where frame_tick=1; overlap between ticks is ignored.
REQ-020 FSM states: ARMED, IMMUNE, DEAD.
REQ-021 ARMED, frame_tick & overlap: wasHit=1 in the next cycle only, lives_left decrements by 1 in that same next cycle; go to IMMUNE with frame counter=0 if the new lives_left>0, otherwise go to DEAD.
REQ-022 IMMUNE: counter increments on each frame_tick; on the tick where counter reaches IFRAMES-1, return to ARMED; overlap on any IMMUNE tick, including that last tick, SHALL NOT produce a hit.
REQ-023 DEAD: absorbing until rst; wasHit stays 0, lives_left stays 0, game_over=1.
REQ-024 wasHit SHALL never be high for two consecutive cycles, and SHALL be at most one pulse per frame_tick.
REQ-025 lives_left SHALL never underflow below 0.
REQ-026 player_visible: 1 in ARMED, 0 in DEAD; in IMMUNE per REQ-031/032.

Reset
REQ-027 rst=1 at a clock edge SHALL force state=ARMED, lives_left=3, wasHit=0, game_over=0, player_visible=1, frame and blink counters=0.
REQ-028 rst SHALL take priority over frame_tick and any pending hit in the same cycle; no wasHit pulse follows a reset cycle.
REQ-029 Reset during IMMUNE or DEAD SHALL return to ARMED with full lives; the next hit requires a fresh overlap on a later frame_tick.

Configuration
REQ-030 Macro HIT_FLASH_EN selects invincibility blinking.
REQ-031 With HIT_FLASH_EN defined: on IMMUNE entry player_visible=0; it toggles after every FLASH_FRAMES frame_ticks while in IMMUNE; it is forced to 1 on return to ARMED.
REQ-032 Without HIT_FLASH_EN: player_visible=1 throughout IMMUNE; blink counter is not built.

Verification
REQ-033 Reset, player (100,100), hazard (108,108) valid, one frame_tick -> wasHit=1 the next cycle only, lives_left 3->2, state IMMUNE.
REQ-034 Player (100,100), hazard (116,100) (edge touch), 10 frame_ticks -> wasHit stays 0, lives_left=3.
REQ-035 IFRAMES=60, overlap held continuously -> hits on tick 1, tick 62, and tick 123; after the third hit lives_left=0, game_over=1, no further wasHit over 200 more ticks.
REQ-036 Overlap held, haz_valid=0 -> no hit; set haz_valid=1 on tick 5 -> wasHit on the cycle after tick 5.
REQ-037 HIT_FLASH_EN defined, FLASH_FRAMES=4 -> after a hit, player_visible = 0 for ticks 1-4, 1 for ticks 5-8, alternating; 1 again on re-arm. Without the macro -> constant 1.
REQ-038 Assert rst in the same cycle as a hitting frame_tick while in IMMUNE with lives_left=2 -> next cycle wasHit=0, lives_left=3, state ARMED.

Source files
------------

// File: rtl/hit_event_gen.sv
// Player/hazard collision detector with three-life ARMED/IMMUNE/DEAD state machine.
// Optional invincibility blinking is compiled in when the HIT_FLASH_EN macro is defined.
module hit_event_gen #(
  parameter int PW           = 16,
  parameter int PH           = 16,
  parameter int HW           = 16,
  parameter int HH           = 16,
  parameter int IFRAMES      = 60,
  parameter int FLASH_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic [9:0] haz_x,
  input  logic [9:0] haz_y,
  input  logic       haz_valid,
  output logic       wasHit,
  output logic [1:0] lives_left,
  output logic       game_over,
  output logic       player_visible
);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    IMMUNE = 2'd1,
    DEAD   = 2'd2
  } state_t;

  localparam logic [10:0] PW_L     = 11'(PW);
  localparam logic [10:0] PH_L     = 11'(PH);
  localparam logic [10:0] HW_L     = 11'(HW);
  localparam logic [10:0] HH_L     = 11'(HH);
  localparam logic [7:0]  IFR_LAST = 8'(IFRAMES - 1);

  // 11-bit extents so a sprite near the right/bottom edge cannot wrap to 0.
  logic [10:0] px_w, py_w, hx_w, hy_w;
  logic [10:0] px_end, py_end, hx_end, hy_end;
  logic        overlap;

  assign px_w   = {1'b0, player_x};
  assign py_w   = {1'b0, player_y};
  assign hx_w   = {1'b0, haz_x};
  assign hy_w   = {1'b0, haz_y};
  assign px_end = px_w + PW_L;
  assign py_end = py_w + PH_L;
  assign hx_end = hx_w + HW_L;
  assign hy_end = hy_w + HH_L;

  assign overlap = haz_valid
                 & (px_w < hx_end) & (hx_w < px_end)
                 & (py_w < hy_end) & (hy_w < py_end);

  state_t      state_q;
  logic [7:0]  frame_cnt_q;
  logic        was_hit_q;
  logic [1:0]  lives_q;
  logic        game_over_q;
  logic        visible_q;

`ifdef HIT_FLASH_EN
  localparam logic [3:0] FLASH_LAST = 4'(FLASH_FRAMES - 1);
  logic [3:0] blink_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARMED;
      frame_cnt_q <= 8'd0;
      was_hit_q   <= 1'b0;
      lives_q     <= 2'd3;
      game_over_q <= 1'b0;
      visible_q   <= 1'b1;
`ifdef HIT_FLASH_EN
      blink_cnt_q <= 4'd0;
`endif
    end else begin
      was_hit_q <= 1'b0;
      case (state_q)
        ARMED: begin
          visible_q <= 1'b1;
          if (frame_tick && overlap && (lives_q != 2'd0)) begin
            was_hit_q   <= 1'b1;
            lives_q     <= lives_q - 2'd1;
            frame_cnt_q <= 8'd0;
            if (lives_q == 2'd1) begin
              state_q     <= DEAD;
              game_over_q <= 1'b1;
              visible_q   <= 1'b0;
            end else begin
              state_q <= IMMUNE;
`ifdef HIT_FLASH_EN
              visible_q   <= 1'b0;
              blink_cnt_q <= 4'd0;
`else
              visible_q   <= 1'b1;
`endif
            end
          end
        end
        IMMUNE: begin
          if (frame_tick) begin
`ifdef HIT_FLASH_EN
            if (blink_cnt_q == FLASH_LAST) begin
              blink_cnt_q <= 4'd0;
              visible_q   <= ~visible_q;
            end else begin
              blink_cnt_q <= blink_cnt_q + 4'd1;
            end
`endif
            // Re-arm assignment comes last so it overrides any blink toggle.
            if (frame_cnt_q == IFR_LAST) begin
              state_q     <= ARMED;
              frame_cnt_q <= 8'd0;
              visible_q   <= 1'b1;
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
        end
        DEAD: begin
          lives_q     <= 2'd0;
          game_over_q <= 1'b1;
          visible_q   <= 1'b0;
        end
        default: begin
          state_q <= ARMED;
        end
      endcase
    end
  end

  assign wasHit         = was_hit_q;
  assign lives_left     = lives_q;
  assign game_over      = game_over_q;
  assign player_visible = visible_q;

endmodule

// File: tb/tb_hit_event_gen.sv
// Directed self-checking bench for hit_event_gen with hand-computed expectations.
// Blink expectations follow HIT_FLASH_EN when the bench is built with that macro.
module tb_hit_event_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic [9:0] player_x, player_y, haz_x, haz_y;
  logic       haz_valid;
  logic       wasHit;
  logic [1:0] lives_left;
  logic       game_over;
  logic       player_visible;

  int checks = 0;
  int errors = 0;

  hit_event_gen dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .player_x       (player_x),
    .player_y       (player_y),
    .haz_x          (haz_x),
    .haz_y          (haz_y),
    .haz_valid      (haz_valid),
    .wasHit         (wasHit),
    .lives_left     (lives_left),
    .game_over      (game_over),
    .player_visible (player_visible)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_tick = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_pos(input int px, input int py, input int hx, input int hy, input logic v);
    player_x  = 10'(px);
    player_y  = 10'(py);
    haz_x     = 10'(hx);
    haz_y     = 10'(hy);
    haz_valid = v;
  endtask

  // One frame: tick cycle then one idle cycle; wasHit must be low in the idle cycle.
  task automatic do_tick(output logic hit);
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    hit = wasHit;
    @(posedge clk);
    #1;
    check_eq("no_double_pulse", {31'd0, wasHit}, 32'd0);
    $display("tick p=(%0d,%0d) h=(%0d,%0d) v=%0b hit=%0b lives=%0d go=%0b vis=%0b",
             player_x, player_y, haz_x, haz_y, haz_valid, hit, lives_left, game_over, player_visible);
  endtask

  // Visibility during the n-th IMMUNE tick (n starts at 1).
  function automatic logic flash_exp(input int n);
`ifdef HIT_FLASH_EN
    return (((n - 1) / 4) % 2) == 1;
`else
    return 1'b1;
`endif
  endfunction

  // Visibility during overall tick t of the continuous-overlap run.
  function automatic logic run_vis(input int t);
    if (t == 1 || t == 62 || t == 123) return 1'b1;
    if (t > 123) return 1'b0;
    if (t < 62) return flash_exp(t - 1);
    return flash_exp(t - 62);
  endfunction

  function automatic int run_lives(input int t);
    if (t >= 123) return 0;
    if (t >= 62) return 1;
    return 2;
  endfunction

  int edge_tab [4][4] = '{'{100, 100, 116, 100}, '{100, 100, 84, 100},
                          '{100, 100, 100, 116}, '{100, 100, 100, 84}};

  initial begin
    logic h;
    int   hits;

    rst = 1'b1;
    frame_tick = 1'b0;
    set_pos(0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_wasHit", {31'd0, wasHit}, 32'd0);
    check_eq("rst_lives", {30'd0, lives_left}, 32'd3);
    check_eq("rst_game_over", {31'd0, game_over}, 32'd0);
    check_eq("rst_visible", {31'd0, player_visible}, 32'd1);
    rst = 1'b0;

    // Basic hit, then IMMUNE swallows a further overlapping tick.
    set_pos(100, 100, 108, 108, 1'b1);
    do_tick(h);
    check_eq("basic_hit", {31'd0, h}, 32'd1);
    check_eq("basic_lives", {30'd0, lives_left}, 32'd2);
    check_eq("basic_vis_entry", {31'd0, player_visible}, {31'd0, flash_exp(1)});
    do_tick(h);
    check_eq("immune_nohit", {31'd0, h}, 32'd0);
    check_eq("immune_lives", {30'd0, lives_left}, 32'd2);

    // Reset coinciding with a hitting tick while IMMUNE.
    rst = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame_tick = 1'b0;
    check_eq("rst_prio_wasHit", {31'd0, wasHit}, 32'd0);
    check_eq("rst_prio_lives", {30'd0, lives_left}, 32'd3);
    check_eq("rst_prio_visible", {31'd0, player_visible}, 32'd1);
    @(posedge clk);
    #1;
    check_eq("rst_prio_after", {31'd0, wasHit}, 32'd0);
    do_tick(h);
    check_eq("rearm_after_rst_hit", {31'd0, h}, 32'd1);
    check_eq("rearm_after_rst_lives", {30'd0, lives_left}, 32'd2);

    // Overlap between ticks is ignored.
    do_reset();
    set_pos(100, 100, 108, 108, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_eq("no_tick_nohit", {31'd0, wasHit}, 32'd0);
    end
    check_eq("no_tick_lives", {30'd0, lives_left}, 32'd3);

    // Edge contact on all four sides never hits.
    for (int e = 0; e < 4; e++) begin
      do_reset();
      set_pos(edge_tab[e][0], edge_tab[e][1], edge_tab[e][2], edge_tab[e][3], 1'b1);
      for (int t = 0; t < 10; t++) begin
        do_tick(h);
        check_eq("edge_nohit", {31'd0, h}, 32'd0);
      end
      check_eq("edge_lives", {30'd0, lives_left}, 32'd3);
    end

    // One-pixel overlap does hit.
    do_reset();
    set_pos(100, 100, 115, 100, 1'b1);
    do_tick(h);
    check_eq("one_px_hit", {31'd0, h}, 32'd1);

    // Right-edge extent must not wrap in 10 bits.
    do_reset();
    set_pos(1015, 0, 1020, 0, 1'b1);
    do_tick(h);
    check_eq("nowrap_hit", {31'd0, h}, 32'd1);

    // haz_valid gating: hit only once valid on tick 5.
    do_reset();
    set_pos(100, 100, 108, 108, 1'b0);
    for (int t = 1; t <= 5; t++) begin
      if (t == 5) haz_valid = 1'b1;
      do_tick(h);
      check_eq("valid_gate_hit", {31'd0, h}, {31'd0, (t == 5)});
    end

    // Continuous overlap through all three lives, then DEAD.
    do_reset();
    set_pos(100, 100, 108, 108, 1'b1);
    for (int t = 1; t <= 123; t++) begin
      check_eq("run_visible", {31'd0, player_visible}, {31'd0, run_vis(t)});
      do_tick(h);
      check_eq("run_hit", {31'd0, h}, {31'd0, (t == 1 || t == 62 || t == 123)});
      check_eq("run_lives", {30'd0, lives_left}, 32'(run_lives(t)));
    end
    check_eq("dead_game_over", {31'd0, game_over}, 32'd1);
    check_eq("dead_visible", {31'd0, player_visible}, 32'd0);
    hits = 0;
    for (int t = 0; t < 200; t++) begin
      do_tick(h);
      if (h) hits++;
    end
    check_eq("dead_hits", 32'(hits), 32'd0);
    check_eq("dead_lives", {30'd0, lives_left}, 32'd0);
    check_eq("dead_game_over_hold", {31'd0, game_over}, 32'd1);

    // Reset out of DEAD restores full lives and needs a fresh tick to hit.
    do_reset();
    check_eq("dead_rst_lives", {30'd0, lives_left}, 32'd3);
    check_eq("dead_rst_game_over", {31'd0, game_over}, 32'd0);
    check_eq("dead_rst_wasHit", {31'd0, wasHit}, 32'd0);
    do_tick(h);
    check_eq("dead_rst_hit", {31'd0, h}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
